pc_fetch: RTL and testbench

Program-counter register and instruction-fetch sequencer for the multicycle MIPS core. It holds the architectural PC and issues Avalon-MM word reads for the instruction at that PC. It presents the fetched word to the decoder and, on retire, loads the next PC from the `pcnext` stage. It also owns MIPS branch-delay-slot sequencing, so a taken branch or jump redirects only after the delay-slot instruction has retired.

---
 rtl/pc_fetch.sv | 115 +++++++++++
 tb/tb_pc_fetch.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// pc_fetch: architectural PC, Avalon-MM instruction fetch and branch-delay-slot sequencing.
// Optional feature: define PC_FETCH_HALT_EN to halt when the next PC would be address 0.
module pc_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcnext,
    input  logic        redirect,
    input  logic        advance,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        active,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic [3:0]  mem_byteenable,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata
);

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_EXEC   = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        run_q, run_d;
    logic        delay_pending_q, delay_pending_d;
    logic [31:0] delay_target_q, delay_target_d;
    logic [31:0] pc_inc;
    logic [31:0] sel_pc;

    // run_q keeps the core idle for the cycle reset is sampled, so a fetch
    // in flight is dropped and active rises only once reset is released
    // Next-state, next-PC and delay-slot bookkeeping
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        instr_d         = instr_q;
        run_d           = 1'b1;
        delay_pending_d = delay_pending_q;
        delay_target_d  = delay_target_q;
        pc_inc          = pc_q + 32'd4;
        sel_pc          = pc_inc;
        case (state_q)
            S_FETCH: begin
                if (run_q && !mem_waitrequest) begin
                    instr_d = mem_readdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (advance) begin
                    if (delay_pending_q) begin
                        // a branch in the delay slot is ignored: first target wins
                        sel_pc          = delay_target_q;
                        delay_pending_d = 1'b0;
                    end else if (redirect) begin
                        delay_target_d  = pcnext;
                        delay_pending_d = 1'b1;
                        sel_pc          = pc_inc;
                    end else begin
                        sel_pc = pc_inc;
                    end
                    pc_d    = sel_pc & ~32'd3;
                    state_d = S_FETCH;
`ifdef PC_FETCH_HALT_EN
                    if (pc_d == 32'd0) begin
                        state_d = S_HALTED;
                    end
`endif
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_FETCH;
            pc_q            <= RESET_VECTOR;
            instr_q         <= 32'd0;
            run_q           <= 1'b0;
            delay_pending_q <= 1'b0;
            delay_target_q  <= 32'd0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            instr_q         <= instr_d;
            run_q           <= run_d;
            delay_pending_q <= delay_pending_d;
            delay_target_q  <= delay_target_d;
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        pc             = pc_q;
        instr          = instr_q;
        instr_valid    = (state_q == S_EXEC);
        active         = run_q && (state_q != S_HALTED);
        mem_read       = run_q && (state_q == S_FETCH);
        mem_address    = pc_q;
        mem_byteenable = 4'b1111;
    end

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: scoreboard bench for pc_fetch; expected fetches are queued
// as the bench steers the PC and popped each time instr_valid rises.
module tb_pc_fetch;

    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pcnext;
    logic        redirect;
    logic        advance;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        active;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [3:0]  mem_byteenable;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;

    int checks = 0;
    int errors = 0;
    int wait_cnt = 0;
    logic [31:0] exp_q[$];
    logic prev_valid = 1'b0;

    pc_fetch #(.RESET_VECTOR(RV)) dut (
        .clk(clk), .reset(reset), .pcnext(pcnext), .redirect(redirect),
        .advance(advance), .pc(pc), .instr(instr), .instr_valid(instr_valid),
        .active(active), .mem_address(mem_address), .mem_read(mem_read),
        .mem_byteenable(mem_byteenable), .mem_waitrequest(mem_waitrequest),
        .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RV) return 32'h24020005;
        return a ^ 32'h13572468;
    endfunction

    assign mem_readdata    = mem_word(mem_address);
    assign mem_waitrequest = (wait_cnt != 0);

    // memory stall counter: counts down only while a read is presented
    always @(posedge clk) begin
        if (mem_read && wait_cnt != 0) wait_cnt <= wait_cnt - 1;
    end

    // scoreboard: every new instr_valid must match the oldest queued fetch
    always @(negedge clk) begin
        if (instr_valid && !prev_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_empty: fetched pc %h, nothing expected", pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (pc !== e || instr !== mem_word(e)) begin
                    errors++;
                    $display("FAIL sb_fetch: pc %h instr %h, expected pc %h instr %h",
                             pc, instr, e, mem_word(e));
                end
            end
        end
        prev_valid <= instr_valid;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_valid(input string nm);
        for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) tick();
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: instr_valid %b, expected 1", nm, instr_valid);
        end
    endtask

    // retire the current instruction and check the PC it selects
    task automatic do_advance(input logic rd, input logic [31:0] nx,
                              input logic [31:0] exp_pc, input string nm);
        wait_valid(nm);
        exp_q.push_back(exp_pc);
        advance  = 1'b1;
        redirect = rd;
        pcnext   = nx;
        tick();
        advance  = 1'b0;
        redirect = 1'b0;
        checks++;
        if (pc !== exp_pc || mem_address !== exp_pc || mem_read !== 1'b1) begin
            errors++;
            $display("FAIL %s: pc %h addr %h rd %b, expected pc %h rd 1",
                     nm, pc, mem_address, mem_read, exp_pc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (pc !== RV || instr !== 32'd0 || instr_valid !== 1'b0 ||
            mem_read !== 1'b0 || active !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pc %h instr %h v %b rd %b act %b, expected %h 0 0 0 0",
                     pc, instr, instr_valid, mem_read, active, RV);
        end
        exp_q.push_back(RV);
        reset = 1'b0;
        tick();
        checks++;
        if (mem_read !== 1'b1 || mem_address !== RV || active !== 1'b1 ||
            mem_byteenable !== 4'b1111 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_fetch: rd %b addr %h act %b be %b v %b, expected 1 %h 1 1111 0",
                     mem_read, mem_address, active, mem_byteenable, instr_valid, RV);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'h24020005 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL first_instr: v %b instr %h rd %b, expected 1 24020005 0",
                     instr_valid, instr, mem_read);
        end
    endtask

    task automatic test_sequential();
        do_advance(1'b0, 32'h12345678, RV + 32'd4, "seq_pc4");
    endtask

    task automatic test_waitstate();
        wait_valid("ws_pre");
        exp_q.push_back(RV + 32'd8);
        wait_cnt = 3;
        advance  = 1'b1;
        tick();
        advance  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_read !== 1'b1 || mem_address !== RV + 32'd8 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL ws_hold%0d: rd %b addr %h v %b, expected 1 %h 0",
                         i, mem_read, mem_address, instr_valid, RV + 32'd8);
            end
            tick();
        end
        checks++;
        if (instr_valid !== 1'b1 || instr !== mem_word(RV + 32'd8)) begin
            errors++;
            $display("FAIL ws_latch: v %b instr %h, expected 1 %h",
                     instr_valid, instr, mem_word(RV + 32'd8));
        end
    endtask

    task automatic test_branch();
        do_advance(1'b0, 32'd0, RV + 32'h0C, "br_seq_c");
        do_advance(1'b0, 32'd0, RV + 32'h10, "br_seq_10");
        do_advance(1'b1, 32'hBFC00100, RV + 32'h14, "br_slot");
        do_advance(1'b1, 32'h00000040, 32'hBFC00100, "br_target");
        do_advance(1'b0, 32'hDEAD0000, 32'hBFC00104, "br_after");
    endtask

    task automatic test_halt();
        do_advance(1'b1, 32'd0, 32'hBFC00108, "jr0_slot");
        wait_valid("jr0_pre");
`ifdef PC_FETCH_HALT_EN
        advance = 1'b1;
        tick();
        advance = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (active !== 1'b0 || mem_read !== 1'b0 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL halt%0d: act %b rd %b v %b, expected 0 0 0",
                         i, active, mem_read, instr_valid);
            end
            advance = 1'b1;
            tick();
        end
        advance = 1'b0;
`else
        exp_q.push_back(32'd0);
        advance = 1'b1;
        tick();
        advance = 1'b0;
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 32'd0 || active !== 1'b1) begin
            errors++;
            $display("FAIL fetch_zero: rd %b addr %h act %b, expected 1 0 1",
                     mem_read, mem_address, active);
        end
        wait_valid("fetch_zero");
`endif
    endtask

    task automatic test_reset_midfetch();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.push_back(RV);
        tick();
        wait_valid("rm_pre");
        wait_cnt = 10;
        advance  = 1'b1;
        tick();
        advance  = 1'b0;
        tick();
        checks++;
        if (mem_read !== 1'b1 || mem_address !== RV + 32'd4) begin
            errors++;
            $display("FAIL rm_stall: rd %b addr %h, expected 1 %h",
                     mem_read, mem_address, RV + 32'd4);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (mem_read !== 1'b0 || pc !== RV || active !== 1'b0) begin
            errors++;
            $display("FAIL rm_abandon: rd %b pc %h act %b, expected 0 %h 0",
                     mem_read, pc, active, RV);
        end
        wait_cnt = 0;
        tick(); tick();
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'd0) begin
            errors++;
            $display("FAIL rm_nolatch: v %b instr %h, expected 0 0", instr_valid, instr);
        end
        exp_q.push_back(RV);
        reset = 1'b0;
        tick();
        wait_valid("rm_refetch");
    endtask

    initial begin
        reset    = 1'b1;
        advance  = 1'b0;
        redirect = 1'b0;
        pcnext   = 32'd0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_waitstate();
        test_branch();
        test_halt();
        test_reset_midfetch();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d fetches pending, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
